// File: rtl/memory_access_phase.sv
// memory_access_phase: data-memory stage between execute and writeback.
// ALU/branch ops pass in one cycle; loads/stores run one or two word beats.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   ew_*                       micro-op from execute (sampled only in IDLE)
//   mw_stall                   upstream must hold ew_* stable
//   mem_req/gnt/addr/we/wdata  word request channel to data memory
//   mem_rvalid/rdata           response channel (read data or store ack)
//   mw_*                       result bundle to writeback
module memory_access_phase #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int REG_W      = 64,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 8,
  parameter logic [OPCODE_W-1:0] MICRO_LB = 'h20,
  parameter logic [OPCODE_W-1:0] MICRO_LD = 'h21,
  parameter logic [OPCODE_W-1:0] MICRO_LQ = 'h22,
  parameter logic [OPCODE_W-1:0] MICRO_SB = 'h23,
  parameter logic [OPCODE_W-1:0] MICRO_SD = 'h24,
  parameter logic [OPCODE_W-1:0] MICRO_SQ = 'h25
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ew_valid,
  input  logic [OPCODE_W-1:0]   ew_opcode,
  input  logic [REG_ADDR_W-1:0] ew_reg_addr_d,
  input  logic [REG_W-1:0]      ew_d,
  input  logic [ADDR_W-1:0]     ew_mem_addr,
  input  logic [2:0]            ew_offset,
  input  logic [REG_W-1:0]      ew_st_data,
  output logic                  mw_stall,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mw_valid,
  output logic [OPCODE_W-1:0]   mw_opcode,
  output logic [REG_ADDR_W-1:0] mw_reg_addr_d,
  output logic [REG_W-1:0]      mw_d
);

  localparam int BE_W = DATA_W / 8;
  localparam int MW   = 2 * BE_W;
  localparam int DW2  = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] A_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_RSP0,
    S_REQ1,
    S_RSP1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_is_mem;
  logic              w_st;
  logic [3:0]        w_n;
  logic [3:0]        w_sum;
  logic              w_cross;
  logic [MW-1:0]     w_mask;
  logic [DW2-1:0]    w_data128;
  logic              w_cap;
  logic              w_alu;
  logic              w_fin;

  logic [ADDR_W-1:0]     r_addr;
  logic [2:0]            r_off;
  logic [3:0]            r_n;
  logic                  r_cross;
  logic                  r_st;
  logic [MW-1:0]         r_mask;
  logic [DW2-1:0]        r_wdata;
  logic [OPCODE_W-1:0]   r_opcode;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_r0;

  logic                  r_mw_valid;
  logic [OPCODE_W-1:0]   r_mw_opcode;
  logic [REG_ADDR_W-1:0] r_mw_rd;
  logic [REG_W-1:0]      r_mw_d;

  logic [DW2-1:0]    w_cat;
  logic [REG_W-1:0]  w_ldsh;
  logic [REG_W-1:0]  w_ld;

  always_comb begin
    w_is_mem = 1'b0;
    w_st     = 1'b0;
    w_n      = 4'd0;
    unique case (1'b1)
      (ew_opcode == MICRO_LB): begin
        w_is_mem = 1'b1;
        w_n      = 4'd1;
      end
      (ew_opcode == MICRO_LD): begin
        w_is_mem = 1'b1;
        w_n      = 4'd4;
      end
      (ew_opcode == MICRO_LQ): begin
        w_is_mem = 1'b1;
        w_n      = 4'd8;
      end
      (ew_opcode == MICRO_SB): begin
        w_is_mem = 1'b1;
        w_st     = 1'b1;
        w_n      = 4'd1;
      end
      (ew_opcode == MICRO_SD): begin
        w_is_mem = 1'b1;
        w_st     = 1'b1;
        w_n      = 4'd4;
      end
      (ew_opcode == MICRO_SQ): begin
        w_is_mem = 1'b1;
        w_st     = 1'b1;
        w_n      = 4'd8;
      end
      default: ;
    endcase
  end

  assign w_sum   = {1'b0, ew_offset} + w_n;
  assign w_cross = (w_sum > 4'd8);

  // loads carry an all-zero mask so both beats read
  assign w_mask = w_st
    ? (((MW'(1) << w_n) - MW'(1)) << ew_offset)
    : '0;

  assign w_data128 =
    {{(DW2-REG_W){1'b0}}, ew_st_data}
    << {ew_offset, 3'b000};

  assign w_alu = (r_state == S_IDLE)
    && ew_valid && !w_is_mem;
  assign w_cap = (r_state == S_IDLE)
    && ew_valid && w_is_mem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_fin     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cap) w_next = S_REQ0;
      end
      S_REQ0: begin
        mem_req   = 1'b1;
        mem_addr  = r_addr;
        mem_we    = r_mask[BE_W-1:0];
        mem_wdata = r_wdata[DATA_W-1:0];
        if (mem_gnt) w_next = S_RSP0;
      end
      S_RSP0: begin
        if (mem_rvalid) begin
          if (r_cross) begin
            w_next = S_REQ1;
          end else begin
            w_next = S_IDLE;
            w_fin  = 1'b1;
          end
        end
      end
      S_REQ1: begin
        mem_req   = 1'b1;
        mem_addr  = r_addr + A_ONE;
        mem_we    = r_mask[MW-1:BE_W];
        mem_wdata = r_wdata[DW2-1:DATA_W];
        if (mem_gnt) w_next = S_RSP1;
      end
      S_RSP1: begin
        if (mem_rvalid) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mw_stall = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_off    <= '0;
      r_n      <= '0;
      r_cross  <= 1'b0;
      r_st     <= 1'b0;
      r_mask   <= '0;
      r_wdata  <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_r0     <= '0;
    end else begin
      if (w_cap) begin
        r_addr   <= ew_mem_addr;
        r_off    <= ew_offset;
        r_n      <= w_n;
        r_cross  <= w_cross;
        r_st     <= w_st;
        r_mask   <= w_mask;
        r_wdata  <= w_data128;
        r_opcode <= ew_opcode;
        r_rd     <= ew_reg_addr_d;
      end
      if (r_state == S_RSP0 && mem_rvalid) begin
        r_r0 <= mem_rdata;
      end
    end
  end

  // single-beat loads see only the current rdata
  assign w_cat = (r_state == S_RSP1)
    ? {mem_rdata, r_r0}
    : {{DATA_W{1'b0}}, mem_rdata};

  assign w_ldsh = REG_W'(w_cat >> {r_off, 3'b000});

  always_comb begin
    w_ld = w_ldsh;
    unique case (1'b1)
      (r_n == 4'd1): w_ld = REG_W'(w_ldsh[7:0]);
      (r_n == 4'd4): w_ld = REG_W'(w_ldsh[31:0]);
      default:       w_ld = w_ldsh;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mw_valid  <= 1'b0;
      r_mw_opcode <= '0;
      r_mw_rd     <= '0;
      r_mw_d      <= '0;
    end else begin
      r_mw_valid <= 1'b0;
      if (w_alu) begin
        r_mw_valid  <= 1'b1;
        r_mw_opcode <= ew_opcode;
        r_mw_rd     <= ew_reg_addr_d;
        r_mw_d      <= ew_d;
      end else if (w_fin) begin
        r_mw_valid  <= 1'b1;
        r_mw_opcode <= r_opcode;
        r_mw_rd     <= r_rd;
        r_mw_d      <= r_st ? '0 : w_ld;
      end
    end
  end

  assign mw_valid      = r_mw_valid;
  assign mw_opcode     = r_mw_opcode;
  assign mw_reg_addr_d = r_mw_rd;
  assign mw_d          = r_mw_d;

endmodule

// File: tb/tb_memory_access_phase.sv
// tb_memory_access_phase: scoreboard bench for memory_access_phase.
// Memory responder checks beats; monitor checks writeback results.
module tb_memory_access_phase;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LD  = 8'h21;
  localparam logic [7:0] OP_LQ  = 8'h22;
  localparam logic [7:0] OP_SB  = 8'h23;
  localparam logic [7:0] OP_SD  = 8'h24;
  localparam logic [7:0] OP_SQ  = 8'h25;

  logic        clk;
  logic        rstn;
  logic        ew_valid;
  logic [7:0]  ew_opcode;
  logic [4:0]  ew_reg_addr_d;
  logic [63:0] ew_d;
  logic [31:0] ew_mem_addr;
  logic [2:0]  ew_offset;
  logic [63:0] ew_st_data;
  logic        mw_stall;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [7:0]  mem_we;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mw_valid;
  logic [7:0]  mw_opcode;
  logic [4:0]  mw_reg_addr_d;
  logic [63:0] mw_d;

  memory_access_phase #(
    .MICRO_LB(OP_LB), .MICRO_LD(OP_LD),
    .MICRO_LQ(OP_LQ), .MICRO_SB(OP_SB),
    .MICRO_SD(OP_SD), .MICRO_SQ(OP_SQ)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ew_valid(ew_valid),
    .ew_opcode(ew_opcode),
    .ew_reg_addr_d(ew_reg_addr_d),
    .ew_d(ew_d),
    .ew_mem_addr(ew_mem_addr),
    .ew_offset(ew_offset),
    .ew_st_data(ew_st_data),
    .mw_stall(mw_stall),
    .mem_req(mem_req),
    .mem_gnt(mem_gnt),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .mw_valid(mw_valid),
    .mw_opcode(mw_opcode),
    .mw_reg_addr_d(mw_reg_addr_d),
    .mw_d(mw_d)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  we;
    logic [63:0] wd;
    bit          chk;
  } beat_t;

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [63:0] d;
  } mw_t;

  beat_t beat_q[$];
  mw_t   exp_q[$];
  logic [63:0] mem_m [logic [31:0]];

  int n_total = 0;
  int n_bad   = 0;
  int gwait_cfg = 0;
  int req_seen  = 0;
  bit no_rsp = 0;
  bit inj_rv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mrd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 64'h0;
  endfunction

  function automatic bit is_mem(input logic [7:0] op);
    return op inside {OP_LB, OP_LD, OP_LQ,
                      OP_SB, OP_SD, OP_SQ};
  endfunction

  task automatic push_beat(input logic [31:0] a,
                           input logic [7:0] we,
                           input logic [63:0] wd,
                           input bit chk);
    beat_t b;
    b.a = a; b.we = we; b.wd = wd; b.chk = chk;
    beat_q.push_back(b);
  endtask

  // memory responder: grant after gwait_cfg cycles, respond next cycle
  initial begin : responder
    bit          pend;
    logic [31:0] pend_a;
    int          gcnt;
    beat_t       b;
    pend = 0; pend_a = '0; gcnt = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = '0;
      if (pend && !no_rsp) begin
        mem_rvalid = 1;
        mem_rdata = mrd(pend_a);
      end
      if (inj_rv) begin
        mem_rvalid = 1;
        mem_rdata = 64'hDEADBEEFDEADBEEF;
      end
      pend = 0;
      if (rstn && mem_req) begin
        req_seen++;
        check("req_stall", 64'(mw_stall), 64'd1);
        if (beat_q.size() == 0) begin
          check("beat_unexp", 64'd1, 64'd0);
        end else begin
          b = beat_q[0];
          check("beat_addr", 64'(mem_addr), 64'(b.a));
          check("beat_we", 64'(mem_we), 64'(b.we));
          if (b.chk)
            check("beat_wdata", mem_wdata, b.wd);
          if (gcnt >= gwait_cfg) begin
            mem_gnt = 1;
            void'(beat_q.pop_front());
            pend = 1;
            pend_a = mem_addr;
            gcnt = 0;
          end else begin
            gcnt++;
          end
        end
      end
    end
  end

  // writeback monitor
  initial begin : monitor
    mw_t e;
    forever begin
      @(negedge clk);
      if (rstn && mw_valid) begin
        if (exp_q.size() == 0) begin
          check("mw_unexp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("mw_op", 64'(mw_opcode), 64'(e.op));
          check("mw_rd", 64'(mw_reg_addr_d), 64'(e.rd));
          check("mw_d", mw_d, e.d);
        end
      end
    end
  end

  task automatic do_op(input string tag,
                       input logic [7:0] opc,
                       input logic [4:0] rd,
                       input logic [63:0] d,
                       input logic [31:0] addr,
                       input logic [2:0] off,
                       input logic [63:0] st,
                       input logic [63:0] exp_d,
                       input int gw,
                       input int exp_lat);
    int lat;
    mw_t e;
    gwait_cfg = gw;
    ew_valid = 1;
    ew_opcode = opc;
    ew_reg_addr_d = rd;
    ew_d = d;
    ew_mem_addr = addr;
    ew_offset = off;
    ew_st_data = st;
    e.op = opc; e.rd = rd; e.d = exp_d;
    exp_q.push_back(e);
    @(negedge clk);
    lat = 1;
    if (is_mem(opc)) begin
      // junk while stalled must be ignored
      ew_opcode = OP_ADD;
      ew_d = 64'($urandom);
      ew_mem_addr = $urandom;
      ew_offset = 3'($urandom);
      ew_st_data = {$urandom, $urandom};
      ew_reg_addr_d = 5'($urandom);
    end else begin
      ew_valid = 0;
    end
    while (!mw_valid && lat < 40) begin
      check({tag, "_stall"}, 64'(mw_stall), 64'd1);
      @(negedge clk);
      lat++;
    end
    ew_valid = 0;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall0"}, 64'(mw_stall), 64'd0);
    @(negedge clk);
  endtask

  initial begin : main
    int r0;
    rstn = 0;
    ew_valid = 0;
    ew_opcode = '0;
    ew_reg_addr_d = '0;
    ew_d = '0;
    ew_mem_addr = '0;
    ew_offset = '0;
    ew_st_data = '0;
    #1;
    check("rst_stall", 64'(mw_stall), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_valid", 64'(mw_valid), 64'd0);
    check("rst_d", mw_d, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);

    r0 = req_seen;
    do_op("add", OP_ADD, 5'd3, 64'h1234, 32'h0, 3'd0,
          64'h0, 64'h1234, 0, 1);
    check("add_noreq", 64'(req_seen - r0), 64'd0);

    mem_m[32'h10] = 64'h8877665544332211;
    push_beat(32'h10, 8'h00, 64'h0, 0);
    do_op("lq", OP_LQ, 5'd4, 64'h0, 32'h10, 3'd0,
          64'h0, 64'h8877665544332211, 0, 3);

    mem_m[32'h10] = 64'hBBAA000000000000;
    mem_m[32'h11] = 64'h000000000000DDCC;
    push_beat(32'h10, 8'h00, 64'h0, 0);
    push_beat(32'h11, 8'h00, 64'h0, 0);
    do_op("ld_x", OP_LD, 5'd5, 64'h0, 32'h10, 3'd6,
          64'h0, 64'hDDCCBBAA, 0, 5);

    mem_m[32'h30] = 64'hFFEEDDCCBBAA9988;
    push_beat(32'h30, 8'h00, 64'h0, 0);
    do_op("lb", OP_LB, 5'd6, 64'h0, 32'h30, 3'd2,
          64'h0, 64'hAA, 0, 3);
    push_beat(32'h30, 8'h00, 64'h0, 0);
    do_op("ld1", OP_LD, 5'd6, 64'h0, 32'h30, 3'd1,
          64'h0, 64'hCCBBAA99, 0, 3);

    push_beat(32'h20, 8'hF8, 64'h0504030201000000, 1);
    push_beat(32'h21, 8'h07, 64'h0000000000080706, 1);
    do_op("sq_x", OP_SQ, 5'd7, 64'h0, 32'h20, 3'd3,
          64'h0807060504030201, 64'h0, 0, 5);

    push_beat(32'hFFFFFFFF, 8'h80, 64'hAB00000000000000, 1);
    do_op("sb7", OP_SB, 5'd8, 64'h0, 32'hFFFFFFFF, 3'd7,
          64'hAB, 64'h0, 0, 3);

    push_beat(32'hFFFFFFFF, 8'hE0, 64'h2233440000000000, 1);
    push_beat(32'h00000000, 8'h01, 64'h0000000000000011, 1);
    do_op("sd_wrap", OP_SD, 5'd9, 64'h0, 32'hFFFFFFFF, 3'd5,
          64'h11223344, 64'h0, 0, 5);

    push_beat(32'h40, 8'h0F, 64'h00000000CAFEF00D, 1);
    do_op("sd_wait", OP_SD, 5'd10, 64'h0, 32'h40, 3'd0,
          64'hCAFEF00D, 64'h0, 4, 7);

    do_op("add2", OP_ADD, 5'd11, 64'hFEDCBA9876543210,
          32'h0, 3'd0, 64'h0, 64'hFEDCBA9876543210, 0, 1);

    // reset while the response is pending
    gwait_cfg = 0;
    no_rsp = 1;
    push_beat(32'h50, 8'h00, 64'h0, 0);
    ew_valid = 1;
    ew_opcode = OP_LQ;
    ew_reg_addr_d = 5'd12;
    ew_mem_addr = 32'h50;
    ew_offset = 3'd0;
    @(negedge clk);
    ew_valid = 0;
    check("ra_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    check("ra_rsp_stall", 64'(mw_stall), 64'd1);
    rstn = 0;
    #1;
    check("ra_stall", 64'(mw_stall), 64'd0);
    check("ra_req0", 64'(mem_req), 64'd0);
    check("ra_we", 64'(mem_we), 64'd0);
    check("ra_wdata", mem_wdata, 64'd0);
    check("ra_valid", 64'(mw_valid), 64'd0);
    check("ra_op", 64'(mw_opcode), 64'd0);
    check("ra_d", mw_d, 64'd0);
    @(negedge clk);
    rstn = 1;
    no_rsp = 0;
    inj_rv = 1;
    @(negedge clk);
    inj_rv = 0;
    repeat (4) begin
      @(negedge clk);
      check("ra_late_valid", 64'(mw_valid), 64'd0);
      check("ra_late_stall", 64'(mw_stall), 64'd0);
    end

    push_beat(32'h10, 8'h00, 64'h0, 0);
    mem_m[32'h10] = 64'h0102030405060708;
    do_op("lq_post", OP_LQ, 5'd13, 64'h0, 32'h10, 3'd0,
          64'h0, 64'h0102030405060708, 0, 3);

    check("beat_q_empty", 64'(beat_q.size()), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
